// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches 16-bit words from imem and queues them for decode.
// Optional branch hold when FETCH_HOLD_ON_BRANCH_EN is defined.
`timescale 1ns/1ps
module instr_fetch_unit #(
  parameter int                ADDR_W     = 8,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imemReq,
  output logic [ADDR_W-1:0] imemAddr,
  input  logic              imemValid,
  input  logic [15:0]       imemData,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instrPC,
  output logic              instrValid,
  input  logic              instrReady,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirectPC,
  input  logic              resume
);

  localparam int                PTR_W    = $clog2(FIFO_DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_e;

  state_e            state_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] fetch_pc_q;

  logic [15:0]       data_mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] pc_mem_q   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;

  logic push, pop, hold_d, can_issue;

  // Redirect overrides everything: a same-cycle response is dropped and a same-cycle pop is ignored.
  assign push    = (state_q == WAIT) && imemValid && !redirect;
  assign pop     = (count_q != '0) && instrReady && !redirect;
  assign count_d = redirect ? '0 : (count_q + CNT_W'(push) - CNT_W'(pop));

`ifdef FETCH_HOLD_ON_BRANCH_EN
  logic hold_q;

  // NOTE: always_comb assigns every output a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    hold_d = hold_q;
    if (redirect)                   hold_d = 1'b0;
    else if (push && imemData[15])  hold_d = 1'b1;
    else if (resume)                hold_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= 1'b0;
    else        hold_q <= hold_d;
  end
`else
  logic unused_resume;
  assign unused_resume = resume;
  assign hold_d        = 1'b0;
`endif

  // Next-cycle occupancy and hold decide issue, so a request goes out the cycle after a response.
  assign can_issue = (count_d < FULL_CNT) && !hold_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else if (redirect) begin
      fetch_pc_q <= redirectPC;
      if (state_q == WAIT && !imemValid) begin
        state_q <= DISCARD;
      end else if (state_q != IDLE && imemValid) begin
        state_q <= IDLE;
        req_q   <= 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (can_issue) begin
            state_q <= WAIT;
            req_q   <= 1'b1;
            addr_q  <= fetch_pc_q;
          end
        end
        WAIT: begin
          if (imemValid) begin
            fetch_pc_q <= fetch_pc_q + PC_ONE;
            if (can_issue) begin
              addr_q <= fetch_pc_q + PC_ONE;
            end else begin
              state_q <= IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (imemValid) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the small prefetch store is reset so instr/instrPC read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      count_q <= count_d;
      if (redirect) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          data_mem_q[wr_ptr_q] <= imemData;
          pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
          wr_ptr_q             <= wr_ptr_q + PTR_ONE;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  assign imemReq    = req_q;
  assign imemAddr   = addr_q;
  assign instr      = data_mem_q[rd_ptr_q];
  assign instrPC    = pc_mem_q[rd_ptr_q];
  assign instrValid = (count_q != '0);

endmodule
